// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
package alu_pkg;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] OP_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_NOR  = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_SLT  = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_MUL  = 4'b1000;
    localparam logic [CTRL_W-1:0] OP_DIVU = 4'b1001;
    localparam logic [CTRL_W-1:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide (shift-subtract),
// one step per clock, WIDTH steps per operation.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CTRL_W-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc is the product for MUL and the partial remainder for DIVU/REMU;
    // opa is the multiplier (shifting right) or the quotient (shifting left).
    logic [WIDTH-1:0] acc, opa, opb;
    logic [CNT_W-1:0] cnt;
    logic             is_div, is_rem;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] trial;

    always_comb begin
        shifted = {acc, opa[WIDTH-1]};
        ge      = shifted >= {1'b0, opb};
        trial   = shifted[WIDTH-1:0] - opb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            is_rem <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            opa    <= a;
            opb    <= b;
            cnt    <= CNT_W'(WIDTH);
            is_div <= (op == OP_DIVU) || (op == OP_REMU);
            is_rem <= (op == OP_REMU);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                // B==0 needs no special case: every step succeeds, so the
                // quotient fills with ones and A shifts whole into the remainder.
                acc <= ge ? trial : shifted[WIDTH-1:0];
                opa <= {opa[WIDTH-2:0], ge};
            end else begin
                if (opa[0]) acc <= acc + opb;
                opa <= opa >> 1;
                opb <= opb << 1;
            end
        end
    end

    assign done   = (cnt == '0);
    assign result = is_div ? (is_rem ? acc : opa) : acc;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative MUL/DIVU/REMU,
// with valid/ready handshakes on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  ALU_src_1,
    input  logic [WIDTH-1:0]  ALU_src_2,
    input  logic [CTRL_W-1:0] ALU_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ALU_out,
    output logic              zero,
    output logic              ovf,
    output logic              dbz
);
    state_t           state;
    logic             dbz_pend;
    logic             is_multi, is_div, start;
    logic [WIDTH-1:0] sum, diff, res_sc;
    logic             ovf_sc;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    always_comb begin
        sum      = ALU_src_1 + ALU_src_2;
        diff     = ALU_src_1 - ALU_src_2;
        is_div   = (ALU_control == OP_DIVU) || (ALU_control == OP_REMU);
        is_multi = is_div || (ALU_control == OP_MUL);
        start    = (state == IDLE) && in_valid && is_multi;
        res_sc   = '0;
        ovf_sc   = 1'b0;
        case (ALU_control)
            OP_AND: res_sc = ALU_src_1 & ALU_src_2;
            OP_OR:  res_sc = ALU_src_1 | ALU_src_2;
            OP_NOR: res_sc = ~(ALU_src_1 | ALU_src_2);
            OP_SLT: res_sc = {{(WIDTH-1){1'b0}}, $signed(ALU_src_1) < $signed(ALU_src_2)};
            OP_ADD: begin
                res_sc = sum;
                ovf_sc = (ALU_src_1[WIDTH-1] == ALU_src_2[WIDTH-1]) &&
                         (sum[WIDTH-1] != ALU_src_1[WIDTH-1]);
            end
            OP_SUB: begin
                res_sc = diff;
                ovf_sc = (ALU_src_1[WIDTH-1] != ALU_src_2[WIDTH-1]) &&
                         (diff[WIDTH-1] != ALU_src_1[WIDTH-1]);
            end
            default: res_sc = '0;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (ALU_control),
        .a      (ALU_src_1),
        .b      (ALU_src_2),
        .done   (iter_done),
        .result (iter_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ALU_out  <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
            dbz_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (is_multi) begin
                        dbz_pend <= is_div && (ALU_src_2 == '0);
                        state    <= BUSY;
                    end else begin
                        ALU_out <= res_sc;
                        ovf     <= ovf_sc;
                        dbz     <= 1'b0;
                        state   <= DONE;
                    end
                end
                BUSY: if (iter_done) begin
                    ALU_out <= iter_result;
                    ovf     <= 1'b0;
                    dbz     <= dbz_pend;
                    state   <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (ALU_out == '0);
endmodule

// File: tb/tb_alu_mc.sv
// Randomised, model-checked bench for alu_mc (WIDTH=32).
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] ALU_src_1, ALU_src_2, ALU_out;
    logic [3:0]   ALU_control;
    logic         zero, ovf, dbz;

    int total = 0;
    int bad   = 0;

    alu_mc #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_src_1(ALU_src_1), .ALU_src_2(ALU_src_2), .ALU_control(ALU_control),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_out(ALU_out),
        .zero(zero), .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic rules, using wide signed/unsigned math.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic o, output logic d);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 1'b0; d = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = ~(a | b);
            4'b0010: begin s = sa + sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0100: r = (sa < sb) ? 1 : 0;
            4'b1000: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
            4'b1001: begin d = (b == 0); r = d ? '1 : a / b; end
            4'b1010: begin d = (b == 0); r = d ? a : a % b; end
            default: r = '0;
        endcase
    endtask

    // Drives one operation and reports what the DUT showed; comparisons live in the callers.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output logic [W-1:0] r, output logic o, output logic d,
                          output logic z, output int lat, output logic rdy_bad,
                          output logic stable_bad, output logic post_idle);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        ALU_control = op; ALU_src_1 = a; ALU_src_2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid    = 1'($urandom_range(0, 1));
        ALU_src_1   = $urandom;
        ALU_src_2   = $urandom;
        ALU_control = 4'($urandom);
        out_ready   = 1'b1;
        lat = 0; rdy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        r = ALU_out; o = ovf; d = dbz; z = zero;
        stable_bad = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ALU_out !== r || ovf !== o || dbz !== d || zero !== z || out_valid !== 1'b1)
                stable_bad = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        post_idle = in_ready && !out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALU_src_1 = '0; ALU_src_2 = '0; ALU_control = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (ALU_out !== '0) begin bad++; $display("FAIL reset_alu_out got=%h want=0", ALU_out); end
        total++; if ({zero, ovf, dbz} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b want=100", {zero, ovf, dbz}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if (lat !== 0) begin bad++; $display("FAIL add_latency got=%0d want=0", lat); end
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", r); end
        total++; if ({o, z, d} !== 3'b100) begin bad++; $display("FAIL add_flags ovf,zero,dbz got=%b want=100", {o, z, d}); end
    endtask

    task automatic test_single();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        run_op(4'b0110, 32'd5, 32'd5, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, z, o} !== {32'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL sub_zero got=%h z=%b o=%b want=0 z=1 o=0", r, z, o); end
        run_op(4'b0100, 32'hFFFF_FFFF, 32'd1, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL slt_neg got=%h want=1", r); end
        run_op(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, z, o, d} !== {32'd0, 3'b100}) begin bad++; $display("FAIL undef_op got=%h z=%b o=%b d=%b want=0 100", r, z, o, d); end
    endtask

    task automatic test_mul();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        run_op(4'b1000, 32'h0001_0000, 32'h0001_0003, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if (lat !== W + 1) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", lat, W + 1); end
        total++; if (r !== 32'h0003_0000) begin bad++; $display("FAIL mul_result got=%h want=00030000", r); end
        total++; if (rb !== 1'b0) begin bad++; $display("FAIL mul_in_ready_busy got=%b want=0", rb); end
    endtask

    task automatic test_div();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        run_op(4'b1001, 32'd100, 32'd7, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, d} !== {32'd14, 1'b0}) begin bad++; $display("FAIL divu_100_7 got=%0d dbz=%b want=14 0", r, d); end
        run_op(4'b1010, 32'd100, 32'd7, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, d} !== {32'd2, 1'b0}) begin bad++; $display("FAIL remu_100_7 got=%0d dbz=%b want=2 0", r, d); end
        run_op(4'b1001, 32'd9, 32'd0, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, d} !== {32'hFFFF_FFFF, 1'b1}) begin bad++; $display("FAIL divu_by0 got=%h dbz=%b want=ffffffff 1", r, d); end
        total++; if (lat !== W + 1) begin bad++; $display("FAIL divu_by0_latency got=%0d want=%0d", lat, W + 1); end
        run_op(4'b1010, 32'd9, 32'd0, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, d} !== {32'd9, 1'b1}) begin bad++; $display("FAIL remu_by0 got=%h dbz=%b want=9 1", r, d); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        run_op(4'b0110, 32'h8000_0000, 32'd1, 10, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, o} !== {32'h7FFF_FFFF, 1'b1}) begin bad++; $display("FAIL bp_result got=%h ovf=%b want=7fffffff 1", r, o); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL bp_stable got=%b want=0", sb); end
        total++; if (pi !== 1'b1) begin bad++; $display("FAIL bp_release_idle got=%b want=1", pi); end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] r; logic o, d, z, rb, sb, pi; int lat;
        @(negedge clk);
        ALU_control = 4'b1001; ALU_src_1 = 32'h1234_5678; ALU_src_2 = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL midrst_state rdy,vld got=%b want=10", {in_ready, out_valid}); end
        total++; if ({ALU_out, dbz} !== {32'd0, 1'b0}) begin bad++; $display("FAIL midrst_out got=%h dbz=%b want=0 0", ALU_out, dbz); end
        @(negedge clk); rst = 1'b0;
        run_op(4'b0010, 32'd2, 32'd3, 0, r, o, d, z, lat, rb, sb, pi);
        total++; if ({r, o, d, z} !== {32'd5, 3'b000}) begin bad++; $display("FAIL midrst_add got=%h o,d,z=%b want=5 000", r, {o, d, z}); end
        total++; if (lat !== 0) begin bad++; $display("FAIL midrst_add_latency got=%0d want=0", lat); end
    endtask

    task automatic test_random();
        logic [3:0] ops [10];
        logic [W-1:0] r, a, b, er; logic o, d, z, rb, sb, pi, eo, ed; int lat, elat;
        logic [3:0] op;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0100, 4'b1000, 4'b1001, 4'b1010, 4'b1111};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            model(op, a, b, er, eo, ed);
            elat = (op == 4'b1000 || op == 4'b1001 || op == 4'b1010) ? W + 1 : 0;
            run_op(op, a, b, $urandom_range(0, 2), r, o, d, z, lat, rb, sb, pi);
            total++;
            if (r !== er || o !== eo || d !== ed || z !== (er == 0) || lat !== elat || rb !== 1'b0 || sb !== 1'b0 || pi !== 1'b1) begin
                bad++;
                $display("FAIL rand op=%b a=%h b=%h got=%h o=%b d=%b z=%b lat=%0d rb=%b sb=%b pi=%b want=%h o=%b d=%b lat=%0d",
                         op, a, b, r, o, d, z, lat, rb, sb, pi, er, eo, ed, elat);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_single();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
